// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package hazard_pkg;

    localparam int LD_CNT_W = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_HOLD = '{default: 1'b0};

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};

    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        mem_wb_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};

    // Freeze PC and IF/ID, inject a bubble into ID/EX, let the back end drain.
    localparam pipe_ctrl_t CTRL_LD_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs and register-control outputs between hazard_ctrl (master) and the pipeline (slave).
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ld_use_hz;
    logic             br_taken_ex;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_req;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             stalled;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  ld_use_hz, br_taken_ex, mem_req, mem_ready, halt_req,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, stalled, stall_cycles
    );

    modport slave (
        output ld_use_hz, br_taken_ex, mem_req, mem_ready, halt_req,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, stalled, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (en && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory waits, halt.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LD_STALL_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input logic           clk,
    input logic           reset,
    hazard_ctrl_if.master bus
);

    ctrl_state_t         state, state_nx;
    ctrl_state_t         ret_state, ret_state_nx;
    ctrl_state_t         rule_state;
    logic [LD_CNT_W-1:0] ld_cnt, ld_cnt_nx;
    logic                mem_wait;
    logic                stalled;
    pipe_ctrl_t          ctrl;

    always_comb begin
        ctrl         = CTRL_HOLD;
        state_nx     = state;
        ret_state_nx = ret_state;
        ld_cnt_nx    = ld_cnt;
        // MEMWAIT resolves through the state it interrupted once memory is ready
        rule_state   = (state == MEMWAIT) ? ret_state : state;
        mem_wait     = (state == MEMWAIT) ? !bus.mem_ready
                                          : (bus.mem_req && !bus.mem_ready);

        if (reset) begin
            ctrl = CTRL_HOLD;
        end else if (bus.halt_req || (state == HALT)) begin
            state_nx = HALT;
        end else if (mem_wait) begin
            state_nx = MEMWAIT;
            if (state != MEMWAIT)
                ret_state_nx = state;
        end else if (rule_state == LDSTALL) begin
            ctrl      = CTRL_LD_STALL;
            ld_cnt_nx = ld_cnt - LD_CNT_W'(1);
            state_nx  = (ld_cnt == LD_CNT_W'(1)) ? RUN : LDSTALL;
        end else if (bus.br_taken_ex) begin
            ctrl     = CTRL_BRANCH;
            state_nx = RUN;
        end else if (bus.ld_use_hz) begin
            ctrl     = CTRL_LD_STALL;
            state_nx = RUN;
            if (LD_STALL_CYCLES > 1) begin
                ld_cnt_nx = LD_CNT_W'(LD_STALL_CYCLES - 1);
                state_nx  = LDSTALL;
            end
        end else begin
            ctrl     = CTRL_RUN;
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            ret_state <= RUN;
            ld_cnt    <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_state_nx;
            ld_cnt    <= ld_cnt_nx;
        end
    end

    assign stalled = !reset && !bus.halt_req && (state != HALT) && !ctrl.pc_en;

    assign bus.pc_en       = ctrl.pc_en;
    assign bus.if_id_en    = ctrl.if_id_en;
    assign bus.id_ex_en    = ctrl.id_ex_en;
    assign bus.ex_mem_en   = ctrl.ex_mem_en;
    assign bus.mem_wb_en   = ctrl.mem_wb_en;
    assign bus.if_id_flush = ctrl.if_id_flush;
    assign bus.id_ex_flush = ctrl.id_ex_flush;
    assign bus.stalled     = stalled;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stalled),
        .count (stall_cnt)
    );

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
`endif

    // A load bubble occupies EX, so no branch can resolve while one is pending.
    assert property (@(posedge clk) disable iff (reset)
        ((state == LDSTALL) || ((state == MEMWAIT) && (ret_state == LDSTALL)))
        |-> !bus.br_taken_ex);

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage ARM CPU. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, which are built from enabled DFFs. It resolves load-use stalls, taken-branch flushes, data-memory wait states and halt under a single four-state FSM.

## Interface
- `LD_STALL_CYCLES`, default 1: load-use bubble length in cycles; legal range 1..7.
- `CNT_W`, default 32: stall performance counter width.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ld_use_hz` in 1: ID instruction reads the destination of the load in EX.
- `br_taken_ex` in 1: branch resolved taken in EX.
- `mem_req` in 1: MEM stage is issuing a data-memory access.
- `mem_ready` in 1: data memory completes the access this cycle.
- `halt_req` in 1: halt the pipeline; sticky until reset.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1: register enables.
- `if_id_flush`, `id_ex_flush` out 1: synchronous clear-to-bubble requests, applied at the next edge.
- `stalled` out 1: high when `pc_en` = 0 outside reset and HALT.
- `stall_cycles` out CNT_W: saturating stall counter (see Configuration).

## Operation
- State register `state` ∈ {RUN, LDSTALL, MEMWAIT, HALT}. It also holds `ret_state` (RUN/LDSTALL) and a 3-bit `ld_cnt`.
- Outputs are combinational from `state`, `ld_cnt` and the inputs. While `reset` is high:
  - all enables and flushes are 0;
  - `state` = RUN, `ld_cnt` = 0, `stall_cycles` = 0.
- Priority per cycle, highest first: `reset` > `halt_req`/HALT > memory wait > `br_taken_ex` > `ld_use_hz`.
- **HALT**: all enables 0 and flushes 0. Entered from any state when `halt_req` = 1; enables drop in that same cycle. Leaves only via `reset`.
- **Memory wait**: in RUN or LDSTALL, if `mem_req & !mem_ready`:
  - all enables 0 and no flush;
  - `ret_state` ← `state`, next state MEMWAIT.
- **MEMWAIT**:
  - while `mem_ready` = 0: all enables 0.
  - when `mem_ready` = 1: outputs and next state follow the `ret_state` rules with memory treated as ready.
  - `ld_cnt` is frozen throughout.
- **RUN, no wait**:
  - `br_taken_ex` = 1: all enables 1, `if_id_flush` = `id_ex_flush` = 1; `ld_use_hz` is ignored that cycle.
  - else `ld_use_hz` = 1: `pc_en` = `if_id_en` = 0, `id_ex_flush` = 1, `id_ex_en` = `ex_mem_en` = `mem_wb_en` = 1. If LD_STALL_CYCLES > 1: `ld_cnt` ← LD_STALL_CYCLES−1 and next state LDSTALL.
  - else: all enables 1, no flush.
- **LDSTALL**:
  - outputs match the RUN load-use cycle; `ld_cnt` decrements each cycle.
  - moves to RUN in the cycle `ld_cnt` = 1 (that cycle still stalls).
  - `ld_use_hz` and `br_taken_ex` are ignored. A bubble sits in EX, so `br_taken_ex` = 1 here is an assertion error.
- Every load-use hazard costs exactly LD_STALL_CYCLES stall cycles, excluding MEMWAIT cycles.

## Timing
- Zero-cycle response: an input change affects the enables in the same cycle. The state change is visible after the next `clk` edge.
- Flushes take effect at the same edge as the enables.
- Reset deassertion: the first edge after `reset` falls runs in RUN with normal rules.
- Reset mid-LDSTALL or mid-MEMWAIT: immediately RUN; `ld_cnt` and `ret_state` cleared.
- `mem_ready` = 1 while `mem_req` = 0 is ignored.

## Configuration
- Macro `HAZARD_PERF_CNT_EN`.
- Defined:
  - `stall_cycles` increments on each edge where `stalled` = 1;
  - it saturates at all-ones and clears on `reset`.
- Undefined: no counter logic; `stall_cycles` is tied to 0.

## Structure
- Package `hazard_pkg` holds:
  - `ctrl_state_t` enum {RUN, LDSTALL, MEMWAIT, HALT};
  - `pipe_ctrl_t` struct grouping the five enables and two flushes;
  - `LD_CNT_W` = 3.
- One sub-module, `sat_counter`: a parameterized width, enable, async active-high reset saturating up-counter. It is instantiated only under `HAZARD_PERF_CNT_EN`.

## Test plan
- **Reset**: hold `reset` for 2 cycles with `ld_use_hz` = 1 → all enables 0 and flushes 0; release with all inputs 0 → all enables 1 on the next cycle, `stall_cycles` = 0.
- **Load-use**: LD_STALL_CYCLES = 2, pulse `ld_use_hz` for one cycle → `pc_en` = `if_id_en` = 0 and `id_ex_flush` = 1 for exactly 2 cycles, then all enables 1; `stall_cycles` = 2.
- **Branch vs load-use**: `br_taken_ex` = `ld_use_hz` = 1 in the same cycle → all enables 1 and both flushes 1 for that cycle only; no LDSTALL entry.
- **Wait inside LDSTALL**: LD_STALL_CYCLES = 3; `mem_req` = 1 and `mem_ready` = 0 for 4 cycles during LDSTALL → all enables 0 for those 4 cycles, then the remaining stall cycles complete; total `stalled` cycles = 7.
- **Halt during wait**: `halt_req` = 1 in MEMWAIT → all enables stay 0 indefinitely even after `mem_ready` = 1; `stalled` = 0; `reset` returns to RUN.
- **Counter saturation**: with `HAZARD_PERF_CNT_EN` and CNT_W = 4, 20 stall cycles → `stall_cycles` = 15. Without the macro → `stall_cycles` = 0.
